// File: rtl/rule_pair_dispatcher.sv
// Rule-pair dispatcher: matches one packet key against a masked rule table, two rules per cycle,
// streams the votes to the decision maker and returns its verdict. Optional DM watchdog: DISP_WATCHDOG_EN.
module rule_pair_dispatcher #(
    parameter int KEY_W     = 16,
    parameter int NUM_RULES = 256,
    parameter int ADDR_W    = 8,
    parameter int WD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [KEY_W-1:0]  pkt_key,
    output logic              pkt_ready,
    input  logic              rule_we,
    input  logic [ADDR_W-1:0] rule_addr,
    input  logic [KEY_W-1:0]  rule_value,
    input  logic [KEY_W-1:0]  rule_mask,
    input  logic              rule_enable,
    output logic              rule_busy,
    output logic              dm_ena,
    output logic              dm_start,
    output logic              dm_accept1,
    output logic              dm_accept2,
    input  logic              dm_ready,
    input  logic              dm_accept_all,
    output logic              verdict_valid,
    output logic              verdict_accept,
    input  logic              verdict_ready,
    output logic              verdict_timeout
);

    localparam int PAIR_W = ADDR_W - 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    if ((NUM_RULES % 2) != 0 || (2 ** ADDR_W) != NUM_RULES || WD_CYCLES < 1) begin : gBadParams
        $error("rule_pair_dispatcher: inconsistent parameters");
    end

    logic [1:0]        state;
    logic [KEY_W-1:0]  ruleValue [NUM_RULES];
    logic [KEY_W-1:0]  ruleMask  [NUM_RULES];
    logic [NUM_RULES-1:0] ruleEnable;
    logic [KEY_W-1:0]  keyReg;
    logic [PAIR_W-1:0] pairIdx;
    logic              pktReadyReg;
    logic              waitFirst;
    logic              dmEna;
    logic              dmStart;
    logic              dmAccept1;
    logic              dmAccept2;
    logic              verdictValid;
    logic              verdictAccept;

    logic              handshake;
    logic              writeOk;
    logic [PAIR_W-1:0] pairSel;
    logic [KEY_W-1:0]  keySel;
    logic [ADDR_W-1:0] evenAddr;
    logic [ADDR_W-1:0] oddAddr;
    logic              matchEven;
    logic              matchOdd;

`ifdef DISP_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wdCount;
    logic            verdictTimeout;
    assign verdict_timeout = verdictTimeout;
`else
    assign verdict_timeout = 1'b0;
`endif

    assign handshake = (state == IDLE) && pktReadyReg && pkt_valid;
    assign writeOk   = (state == IDLE) && rule_we;

    // Pair 0 is evaluated on the handshake edge straight from the incoming key
    assign pairSel  = handshake ? '0 : pairIdx;
    assign keySel   = handshake ? pkt_key : keyReg;
    assign evenAddr = {pairSel, 1'b0};
    assign oddAddr  = {pairSel, 1'b1};

    assign matchEven = !ruleEnable[evenAddr] ||
                       ((keySel & ruleMask[evenAddr]) == (ruleValue[evenAddr] & ruleMask[evenAddr]));
    assign matchOdd  = !ruleEnable[oddAddr] ||
                       ((keySel & ruleMask[oddAddr]) == (ruleValue[oddAddr] & ruleMask[oddAddr]));

    assign pkt_ready      = pktReadyReg;
    assign rule_busy      = (state != IDLE);
    assign dm_ena         = dmEna;
    assign dm_start       = dmStart;
    assign dm_accept1     = dmAccept1;
    assign dm_accept2     = dmAccept2;
    assign verdict_valid  = verdictValid;
    assign verdict_accept = verdictAccept;

    // Value and mask need no reset: a cleared enable makes the entry vote accept
    always_ff @(posedge clk) begin
        if (writeOk) begin
            ruleValue[rule_addr] <= rule_value;
            ruleMask[rule_addr]  <= rule_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ruleEnable <= '0;
        end else if (writeOk) begin
            ruleEnable[rule_addr] <= rule_enable;
        end
    end

    // pairIdx holds the next pair to send; its wrap to zero marks the end of the scan
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            keyReg        <= '0;
            pairIdx       <= '0;
            pktReadyReg   <= 1'b0;
            waitFirst     <= 1'b0;
            dmEna         <= 1'b0;
            dmStart       <= 1'b0;
            dmAccept1     <= 1'b0;
            dmAccept2     <= 1'b0;
            verdictValid  <= 1'b0;
            verdictAccept <= 1'b0;
`ifdef DISP_WATCHDOG_EN
            wdCount        <= '0;
            verdictTimeout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    pktReadyReg <= 1'b1;
                    if (handshake) begin
                        keyReg      <= pkt_key;
                        pairIdx     <= PAIR_W'(1);
                        pktReadyReg <= 1'b0;
                        dmEna       <= 1'b1;
                        dmStart     <= 1'b1;
                        dmAccept1   <= matchEven;
                        dmAccept2   <= matchOdd;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    dmStart <= 1'b0;
                    if (pairIdx == '0) begin
                        dmEna     <= 1'b0;
                        dmAccept1 <= 1'b0;
                        dmAccept2 <= 1'b0;
                        waitFirst <= 1'b1;
`ifdef DISP_WATCHDOG_EN
                        wdCount   <= '0;
`endif
                        state     <= WAIT;
                    end else begin
                        dmAccept1 <= matchEven;
                        dmAccept2 <= matchOdd;
                        pairIdx   <= pairIdx + PAIR_W'(1);
                    end
                end
                WAIT: begin
                    waitFirst <= 1'b0;
                    if (!waitFirst && dm_ready) begin
                        verdictValid  <= 1'b1;
                        verdictAccept <= dm_accept_all;
                        state         <= HOLD;
                    end
`ifdef DISP_WATCHDOG_EN
                    else if (wdCount == WD_W'(WD_CYCLES - 1)) begin
                        verdictValid   <= 1'b1;
                        verdictAccept  <= 1'b0;
                        verdictTimeout <= 1'b1;
                        state          <= HOLD;
                    end else begin
                        wdCount <= wdCount + WD_W'(1);
                    end
`endif
                end
                HOLD: begin
                    if (verdict_ready) begin
                        verdictValid  <= 1'b0;
                        verdictAccept <= 1'b0;
`ifdef DISP_WATCHDOG_EN
                        verdictTimeout <= 1'b0;
`endif
                        pktReadyReg   <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rule_pair_dispatcher.sv
// Testbench for rule_pair_dispatcher: behavioural DM model, table-driven rule vectors,
// hand-written multi-cycle sequences and randomized packets against a reference rule table.
module tb_rule_pair_dispatcher;

    localparam int KEY_W     = 16;
    localparam int NUM_RULES = 256;
    localparam int ADDR_W    = 8;
    localparam int WD_CYCLES = 16;
    localparam int PAIRS     = NUM_RULES / 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_valid;
    logic [KEY_W-1:0]  pkt_key;
    logic              pkt_ready;
    logic              rule_we;
    logic [ADDR_W-1:0] rule_addr;
    logic [KEY_W-1:0]  rule_value;
    logic [KEY_W-1:0]  rule_mask;
    logic              rule_enable;
    logic              rule_busy;
    logic              dm_ena;
    logic              dm_start;
    logic              dm_accept1;
    logic              dm_accept2;
    logic              dm_ready = 1'b0;
    logic              dm_accept_all = 1'b0;
    logic              verdict_valid;
    logic              verdict_accept;
    logic              verdict_ready;
    logic              verdict_timeout;

    int checks   = 0;
    int failures = 0;

    logic [KEY_W-1:0] shValue [NUM_RULES];
    logic [KEY_W-1:0] shMask  [NUM_RULES];
    bit               shEn    [NUM_RULES];

    bit               busyWriteEn = 1'b0;
    logic [ADDR_W-1:0] busyAddr;
    logic [KEY_W-1:0] busyValue;

    int dmPairs  = 0;
    int dmDelay  = 0;
    bit dmAll    = 1'b0;
    bit dmSilent = 1'b0;

    always #5 clk = ~clk;

    rule_pair_dispatcher #(
        .KEY_W(KEY_W), .NUM_RULES(NUM_RULES), .ADDR_W(ADDR_W), .WD_CYCLES(WD_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .pkt_valid(pkt_valid), .pkt_key(pkt_key), .pkt_ready(pkt_ready),
        .rule_we(rule_we), .rule_addr(rule_addr), .rule_value(rule_value),
        .rule_mask(rule_mask), .rule_enable(rule_enable), .rule_busy(rule_busy),
        .dm_ena(dm_ena), .dm_start(dm_start), .dm_accept1(dm_accept1), .dm_accept2(dm_accept2),
        .dm_ready(dm_ready), .dm_accept_all(dm_accept_all),
        .verdict_valid(verdict_valid), .verdict_accept(verdict_accept),
        .verdict_ready(verdict_ready), .verdict_timeout(verdict_timeout)
    );

    // DM model: ANDs every received pair and raises readyDM two cycles after the last pair
    always @(posedge clk) begin
        if (dm_ena === 1'b1) begin
            if (dm_start === 1'b1) begin
                dmPairs  <= 1;
                dmAll    <= dm_accept1 & dm_accept2;
                dm_ready <= 1'b0;
            end else begin
                dmPairs <= dmPairs + 1;
                dmAll   <= dmAll & dm_accept1 & dm_accept2;
            end
            dmDelay <= 0;
        end else if (dmPairs == PAIRS) begin
            if (dmDelay == 1) begin
                dmPairs <= 0;
                if (!dmSilent) begin
                    dm_ready      <= 1'b1;
                    dm_accept_all <= dmAll;
                end
            end else begin
                dmDelay <= dmDelay + 1;
            end
        end
    end

    function automatic bit refAccept(input int idx, input logic [KEY_W-1:0] key);
        if (!shEn[idx]) return 1'b1;
        return ((key ^ shValue[idx]) & shMask[idx]) == '0;
    endfunction

    function automatic bit refVerdict(input logic [KEY_W-1:0] key);
        bit acc = 1'b1;
        for (int i = 0; i < NUM_RULES; i++) acc &= refAccept(i, key);
        return acc;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearShadow();
        for (int i = 0; i < NUM_RULES; i++) begin
            shEn[i]    = 1'b0;
            shValue[i] = '0;
            shMask[i]  = '0;
        end
    endtask

    task automatic writeRule(input int addr, input logic [KEY_W-1:0] value,
                             input logic [KEY_W-1:0] mask, input bit en);
        rule_addr   = ADDR_W'(addr);
        rule_value  = value;
        rule_mask   = mask;
        rule_enable = en;
        rule_we     = 1'b1;
        @(posedge clk); #1;
        rule_we     = 1'b0;
        shValue[addr] = value;
        shMask[addr]  = mask;
        shEn[addr]    = en;
    endtask

    // One full packet: handshake, scan checks, verdict latency, hold stability and release
    task automatic applyStimulus(input logic [KEY_W-1:0] key, input int holdCycles, input bit expTimeout,
                                 output bit verdict, output int zeroCount, output int firstZero);
        int n;
        int enaCycles;
        int pairErrs;
        int startErrs;
        int waitCycles;
        int stableErrs;
        bit expVerdict;
        expVerdict = expTimeout ? 1'b0 : refVerdict(key);
        zeroCount  = 0;
        firstZero  = -1;
        verdict    = 1'b0;
        pkt_key    = key;
        pkt_valid  = 1'b1;
        n = 0;
        while (pkt_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("pkt_ready_wait", n < 300, 1);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        pkt_key   = KEY_W'($urandom);
        enaCycles = 0;
        pairErrs  = 0;
        startErrs = 0;
        while (dm_ena === 1'b1 && enaCycles < PAIRS + 8) begin
            if (dm_start !== (enaCycles == 0)) startErrs++;
            if (enaCycles < PAIRS) begin
                if (dm_accept1 !== refAccept(2 * enaCycles, key)) pairErrs++;
                if (dm_accept2 !== refAccept(2 * enaCycles + 1, key)) pairErrs++;
            end
            if (dm_accept1 === 1'b0) begin
                zeroCount++;
                if (firstZero < 0) firstZero = 2 * enaCycles;
            end
            if (dm_accept2 === 1'b0) begin
                zeroCount++;
                if (firstZero < 0) firstZero = 2 * enaCycles + 1;
            end
            if (busyWriteEn && enaCycles == 10) begin
                checkOutput("busy_during_scan", rule_busy, 1);
                rule_addr   = busyAddr;
                rule_value  = busyValue;
                rule_mask   = '1;
                rule_enable = 1'b1;
                rule_we     = 1'b1;
            end else begin
                rule_we = 1'b0;
            end
            enaCycles++;
            @(posedge clk); #1;
        end
        rule_we = 1'b0;
        checkOutput("ena_cycles", enaCycles, PAIRS);
        checkOutput("start_only_first", startErrs, 0);
        checkOutput("pair_accept_bits", pairErrs, 0);
        checkOutput("idle_dm_bits", {dm_start, dm_accept1, dm_accept2}, 0);
        waitCycles = 0;
        while (verdict_valid !== 1'b1 && waitCycles < 60) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        checkOutput("verdict_latency", waitCycles, expTimeout ? WD_CYCLES : 3);
        checkOutput("verdict_accept", verdict_accept, expVerdict);
        checkOutput("verdict_timeout", verdict_timeout, expTimeout);
        checkOutput("pkt_ready_in_hold", pkt_ready, 0);
        verdict    = verdict_accept;
        stableErrs = 0;
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            if (verdict_valid !== 1'b1 || verdict_accept !== verdict ||
                pkt_ready !== 1'b0 || verdict_timeout !== expTimeout) stableErrs++;
        end
        checkOutput("hold_stable", stableErrs, 0);
        verdict_ready = 1'b1;
        @(posedge clk); #1;
        verdict_ready = 1'b0;
        checkOutput("verdict_cleared", {verdict_valid, verdict_timeout}, 0);
        checkOutput("pkt_ready_after_hold", pkt_ready, 1);
    endtask

    typedef struct {
        int               addr;
        logic [KEY_W-1:0] value;
        logic [KEY_W-1:0] mask;
        bit               en;
        logic [KEY_W-1:0] key;
        bit               expVerdict;
        int               expZeros;
        int               expFirstZero;
    } RuleVector;

    initial begin
        RuleVector vecs[9];
        bit v;
        int zc;
        int fz;
        int n;
        int ra[3];

        vecs[0] = '{200, 16'h00AB, 16'h00FF, 1'b1, 16'h12AB, 1'b1, 0, -1};
        vecs[1] = '{200, 16'h00AB, 16'h00FF, 1'b1, 16'h12AC, 1'b0, 1, 200};
        vecs[2] = '{201, 16'h00AB, 16'h00FF, 1'b1, 16'h12AB, 1'b1, 0, -1};
        vecs[3] = '{201, 16'h00AB, 16'h00FF, 1'b1, 16'h12AC, 1'b0, 1, 201};
        vecs[4] = '{0,   16'hF000, 16'hF000, 1'b1, 16'hF123, 1'b1, 0, -1};
        vecs[5] = '{0,   16'hF000, 16'hF000, 1'b1, 16'h0123, 1'b0, 1, 0};
        vecs[6] = '{255, 16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b0, 1, 255};
        vecs[7] = '{255, 16'h0001, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, -1};
        vecs[8] = '{10,  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 0, -1};

        rst = 1'b1;
        pkt_valid = 1'b0;
        pkt_key = '0;
        rule_we = 1'b0;
        rule_addr = '0;
        rule_value = '0;
        rule_mask = '0;
        rule_enable = 1'b0;
        verdict_ready = 1'b0;
        clearShadow();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {pkt_ready, rule_busy, dm_ena, dm_start, dm_accept1, dm_accept2,
                                      verdict_valid, verdict_accept, verdict_timeout}, 0);
        rst = 1'b0;

        // Empty table: every rule votes accept
        applyStimulus(16'h1234, 0, 1'b0, v, zc, fz);
        checkOutput("empty_table_verdict", v, 1);
        checkOutput("empty_table_zeros", zc, 0);

        for (int i = 0; i < 9; i++) begin
            writeRule(vecs[i].addr, vecs[i].value, vecs[i].mask, vecs[i].en);
            applyStimulus(vecs[i].key, 0, 1'b0, v, zc, fz);
            checkOutput($sformatf("vec%0d_verdict", i), v, vecs[i].expVerdict);
            checkOutput($sformatf("vec%0d_zeros", i), zc, vecs[i].expZeros);
            checkOutput($sformatf("vec%0d_first_zero", i), fz, vecs[i].expFirstZero);
            writeRule(vecs[i].addr, '0, '0, 1'b0);
        end

        // Rule write while busy must not land, in this packet or the next
        writeRule(30, 16'h1111, 16'hFFFF, 1'b1);
        busyWriteEn = 1'b1;
        busyAddr    = 8'd30;
        busyValue   = 16'h2222;
        applyStimulus(16'h1111, 0, 1'b0, v, zc, fz);
        busyWriteEn = 1'b0;
        checkOutput("busy_write_same_packet", v, 1);
        applyStimulus(16'h1111, 0, 1'b0, v, zc, fz);
        checkOutput("busy_write_resend", v, 1);
        writeRule(30, '0, '0, 1'b0);

        // Consumer stalls for 10 cycles, then a back-to-back packet
        writeRule(77, 16'h0F00, 16'h0F00, 1'b1);
        applyStimulus(16'h0A00, 10, 1'b0, v, zc, fz);
        checkOutput("stall_verdict", v, 0);
        applyStimulus(16'h0F55, 0, 1'b0, v, zc, fz);
        checkOutput("back_to_back_verdict", v, 1);

        // Asynchronous reset in the middle of the scan
        writeRule(40, 16'h5555, 16'hFFFF, 1'b1);
        pkt_key = 16'h1234;
        pkt_valid = 1'b1;
        n = 0;
        while (pkt_ready !== 1'b1 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        n = 0;
        while (dm_ena === 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("pair50_ena", dm_ena, 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", {pkt_ready, rule_busy, dm_ena, dm_start, dm_accept1, dm_accept2,
                                            verdict_valid, verdict_accept, verdict_timeout}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NUM_RULES; i++) shEn[i] = 1'b0;
        applyStimulus(16'h1234, 0, 1'b0, v, zc, fz);
        checkOutput("post_reset_verdict", v, 1);

        // Randomized rules and keys against the reference table
        for (int it = 0; it < 10; it++) begin
            for (int r = 0; r < 3; r++) begin
                ra[r] = $urandom_range(0, NUM_RULES - 1);
                writeRule(ra[r], KEY_W'($urandom), KEY_W'($urandom) & KEY_W'($urandom) & KEY_W'($urandom),
                          ($urandom_range(0, 3) != 0));
            end
            if ($urandom_range(0, 1) == 1)
                pkt_key = shValue[ra[0]] | (KEY_W'($urandom) & ~shMask[ra[0]]);
            else
                pkt_key = KEY_W'($urandom);
            applyStimulus(pkt_key, $urandom_range(0, 3), 1'b0, v, zc, fz);
            for (int r = 0; r < 3; r++) writeRule(ra[r], '0, '0, 1'b0);
        end

`ifdef DISP_WATCHDOG_EN
        dmSilent = 1'b1;
        applyStimulus(16'h1234, 2, 1'b1, v, zc, fz);
        dmSilent = 1'b0;
        checkOutput("watchdog_verdict", v, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
